relu_backward_layer: RTL and testbench
======================================

Name: relu_backward_layer

Overview:
- Backward-pass counterpart of the forward ReLU layer, used by the on-chip training path.
- Forward phase: accepts each pre-activation vector, CHANNELS x D_WIDTH signed, and stores one sign-mask bit per channel in an internal FIFO.
- Backward phase: for each incoming gradient vector, pops one mask word and passes a channel's gradient where its mask bit is 1, and outputs zero where it is 0.
- Sits between the next layer's gradient output and the previous layer's gradient input. Uses valid/ready handshakes on all three streams.

Parameters:
- D_WIDTH, 16, bit width of each signed channel value (activation and gradient).
- CHANNELS, 8, number of parallel channels per vector.
- DEPTH, 64, number of mask words the FIFO holds; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  global clock enable; when low, all state is frozen.
- fwd_valid  input  1  fwd_data is valid.
- fwd_ready  output  1  mask FIFO can accept a word.
- fwd_data  input  D_WIDTH*CHANNELS  pre-activation vector; channel i is at [D_WIDTH*i +: D_WIDTH].
- grad_in_valid  input  1  grad_in_data is valid.
- grad_in_ready  output  1  block accepts the gradient this cycle.
- grad_in_data  input  D_WIDTH*CHANNELS  upstream gradient vector, same channel packing.
- grad_out_valid  output  1  grad_out_data is valid.
- grad_out_ready  input  1  downstream accepts.
- grad_out_data  output  D_WIDTH*CHANNELS  masked gradient vector.
- mask_count  output  $clog2(DEPTH+1)  number of mask words stored.
- overflow_err  output  1  sticky flag: fwd_valid was high while the FIFO was full.
- underflow_err  output  1  sticky flag: grad_in_valid was high while the FIFO was empty.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and mask_count = 0.
  - grad_out_valid = 0, grad_out_data = 0.
  - Both error flags = 0.
  - fwd_ready = 0 and grad_in_ready = 0 while in reset.
- Reset mid-operation discards all stored masks and any pending output.
- clk_en=0:
  - No state changes.
  - fwd_ready and grad_in_ready are driven 0.
  - grad_out_valid and grad_out_data hold their values; they must not drop while valid is high.
- Mask rule:
  - mask[i] = 1 iff channel i of fwd_data, as a signed value, is > 0.
  - Zero and negative values give 0. The most negative value (0x8000 at D_WIDTH=16) gives 0.
- Push:
  - fwd_ready = clk_en && (mask_count < DEPTH).
  - Push occurs when fwd_valid && fwd_ready; the mask word is written and the write pointer advances.
- Pop:
  - grad_in_ready = clk_en && (mask_count > 0) && (!grad_out_valid || grad_out_ready).
  - On grad_in_valid && grad_in_ready, the oldest mask word is popped.
  - grad_out_data channel i = mask[i] ? grad_in_data channel i : 0.
  - Registered; grad_out_valid asserts the next cycle. Latency is 1 cycle.
- No bypass: a gradient cannot consume a mask pushed in the same cycle. With mask_count=0, grad_in_ready stays 0 even if a push is in progress.
- Simultaneous push and pop:
  - Both are allowed when mask_count is between 1 and DEPTH-1; mask_count is unchanged.
  - When full, push is blocked (fwd_ready=0) even if a pop happens the same cycle. Ready is computed from the registered count only.
- Output stage:
  - grad_out_valid clears on grad_out_ready && !(new pop).
  - Back-to-back pops with grad_out_ready held high sustain 1 vector per cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. mask_count alone distinguishes full from empty.
- Errors:
  - overflow_err sets when fwd_valid && clk_en && mask_count==DEPTH.
  - underflow_err sets when grad_in_valid && clk_en && mask_count==0.
  - Both clear only on reset. Neither corrupts state.
- Arithmetic: the gradient passes through bit-exact; there is no saturation or rescaling.

Decomposition:
- Shared package relu_pkg:
  - mask word type (CHANNELS-bit vector);
  - function relu_mask(vector) returning the mask word;
  - localparam for the count width.
- One sub-module, relu_mask_fifo:
  - parameters DEPTH and WIDTH=CHANNELS;
  - synchronous write and read, registered count, async active-low reset, clk_en gating.
- The top level holds the ready logic, the masking, the output register and the error flags.

Test Plan (D_WIDTH=16, CHANNELS=2, DEPTH=4):
1. Push fwd {ch1=0x0005, ch0=0xFFFB} -> mask_count=1. Then grad_in {0x1234, 0x0777} -> 1 cycle later grad_out_valid=1, data {0x1234, 0x0000}, mask_count=0.
2. Push 4 vectors -> fwd_ready=0, mask_count=4. A fifth fwd_valid sets overflow_err=1; mask_count stays 4.
3. Empty FIFO, grad_in_valid=1 -> grad_in_ready=0 and underflow_err=1. Same-cycle push does not forward; the gradient is accepted next cycle.
4. Fwd values {0x0000, 0x8000}, then gradient {0x7FFF, 0x7FFF} -> output {0x0000, 0x0000}.
5. Hold grad_out_ready=0 with an output pending -> grad_in_ready=0 and output data stable. Then raise ready with 3 pops queued -> 3 outputs on consecutive cycles, in FIFO order.
6. Assert rst_n=0 with mask_count=3 and grad_out_valid=1 -> immediately mask_count=0, grad_out_valid=0, flags cleared. Also check clk_en=0 for 5 cycles freezes all state.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU backward layer: mask word type,
// sign-mask extraction and count-width sizing.
package relu_pkg;

    localparam int MAX_CHANNELS = 64;
    localparam int MAX_D_WIDTH  = 64;
    localparam int MAX_VEC_W    = MAX_CHANNELS * MAX_D_WIDTH;
    localparam int VEC_IDX_W    = $clog2(MAX_VEC_W);

    typedef logic [MAX_CHANNELS-1:0] mask_word_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_COUNT_W = count_width(64);

    // Bit i is set when channel i is strictly positive: sign bit clear and
    // at least one magnitude bit set. Zero-extended channels beyond the real
    // channel count read as zero and therefore give 0.
    function automatic mask_word_t relu_mask(input logic [MAX_VEC_W-1:0] vec,
                                             input int d_width);
        mask_word_t               m;
        logic                     nonzero;
        logic [VEC_IDX_W-1:0]     idx;
        m = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            nonzero = 1'b0;
            for (int j = 0; j < MAX_D_WIDTH - 1; j++) begin
                if (j < d_width - 1) begin
                    idx     = VEC_IDX_W'(i * d_width + j);
                    nonzero = nonzero | vec[idx];
                end
            end
            idx  = VEC_IDX_W'(i * d_width + d_width - 1);
            m[i] = nonzero & ~vec[idx];
        end
        return m;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Sign-mask FIFO: synchronous write, registered read, registered occupancy.
// The count alone separates full from empty; pointers wrap modulo DEPTH.
module relu_mask_fifo
    import relu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] rd_data_reg;

    logic do_wr;
    logic do_rd;

    assign do_wr = clk_en && wr_en;
    assign do_rd = clk_en && rd_en;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/relu_backward_layer.sv
// ReLU backward layer: forward vectors deposit sign masks into a FIFO; each
// gradient vector pops one mask and is zeroed on the non-positive channels.
module relu_backward_layer
    import relu_pkg::*;
#(
    parameter int D_WIDTH  = 16,
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            fwd_valid,
    output logic                            fwd_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]     fwd_data,
    input  logic                            grad_in_valid,
    output logic                            grad_in_ready,
    input  logic [D_WIDTH*CHANNELS-1:0]     grad_in_data,
    output logic                            grad_out_valid,
    input  logic                            grad_out_ready,
    output logic [D_WIDTH*CHANNELS-1:0]     grad_out_data,
    output logic [$clog2(DEPTH+1)-1:0]      mask_count,
    output logic                            overflow_err,
    output logic                            underflow_err
);

    localparam int VEC_W = D_WIDTH * CHANNELS;
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    mask_word_t            fwd_mask_full;
    logic [CHANNELS-1:0]   fwd_mask;
    logic [CHANNELS-1:0]   rd_mask;
    logic [CNT_W-1:0]      count;
    logic [VEC_W-1:0]      grad_reg;
    logic                  out_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  push;
    logic                  pop;

    always_comb begin
        fwd_mask_full = relu_mask(MAX_VEC_W'(fwd_data), D_WIDTH);
    end
    assign fwd_mask = fwd_mask_full[CHANNELS-1:0];

    generate
        if (CHANNELS < MAX_CHANNELS) begin : g_spare_mask
            logic unused_mask_bits;
            assign unused_mask_bits = ^fwd_mask_full[MAX_CHANNELS-1:CHANNELS];
        end
    endgenerate

    // Ready depends only on registered state, so a mask pushed this cycle is
    // never visible to a gradient in the same cycle.
    assign fwd_ready     = rst_n && clk_en && (count < DEPTH_C);
    assign grad_in_ready = rst_n && clk_en && (count != '0) &&
                           (!out_valid_reg || grad_out_ready);

    assign push = fwd_valid && fwd_ready;
    assign pop  = grad_in_valid && grad_in_ready;

    relu_mask_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHANNELS)
    ) u_mask_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .wr_en   (push),
        .wr_data (fwd_mask),
        .rd_en   (pop),
        .rd_data (rd_mask),
        .count   (count)
    );

    // The FIFO read register and grad_reg load on the same edge, so the
    // masked product below is stable until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grad_reg      <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clk_en) begin
            if (pop) begin
                grad_reg      <= grad_in_data;
                out_valid_reg <= 1'b1;
            end else if (grad_out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (fwd_valid && (count == DEPTH_C)) begin
                overflow_reg <= 1'b1;
            end
            if (grad_in_valid && (count == '0)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign grad_out_data[D_WIDTH*gi +: D_WIDTH] =
                rd_mask[gi] ? grad_reg[D_WIDTH*gi +: D_WIDTH] : '0;
        end
    endgenerate

    assign grad_out_valid = out_valid_reg;
    assign mask_count     = count;
    assign overflow_err   = overflow_reg;
    assign underflow_err  = underflow_reg;

endmodule

// File: tb/tb_relu_backward_layer.sv
// Scoreboard bench for relu_backward_layer: a queue-based reference model
// predicts masks, outputs, readiness and flags; a monitor checks outputs.
module tb_relu_backward_layer;

    localparam int DW    = 16;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int VW    = DW * CH;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [VW-1:0] fwd_data;
    logic          grad_in_valid;
    logic          grad_in_ready;
    logic [VW-1:0] grad_in_data;
    logic          grad_out_valid;
    logic          grad_out_ready;
    logic [VW-1:0] grad_out_data;
    logic [CW-1:0] mask_count;
    logic          overflow_err;
    logic          underflow_err;

    always #5 clk = ~clk;

    relu_backward_layer #(
        .D_WIDTH  (DW),
        .CHANNELS (CH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in_data   (grad_in_data),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out_data  (grad_out_data),
        .mask_count     (mask_count),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Reference model: a channel survives iff its forward value is > 0.
    function automatic logic [CH-1:0] ref_mask(input logic [VW-1:0] v);
        logic [CH-1:0] m;
        for (int c = 0; c < CH; c++) m[c] = ($signed(v[DW*c +: DW]) > 0);
        return m;
    endfunction

    function automatic logic [VW-1:0] ref_out(input logic [CH-1:0] m, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        for (int c = 0; c < CH; c++) r[DW*c +: DW] = m[c] ? g[DW*c +: DW] : '0;
        return r;
    endfunction

    logic [CH-1:0] mq[$];
    logic [VW-1:0] exp_q[$];
    bit            pend  = 1'b0;
    bit            ovf_m = 1'b0;
    bit            unf_m = 1'b0;

    // Model: check registered state against the model, then apply this
    // cycle's handshakes shortly before the next rising edge.
    always @(negedge clk) begin
        bit            efr;
        bit            egr;
        bit            do_push;
        bit            do_pop;
        logic [CH-1:0] m;
        if (!rst_n) begin
            chk("rst_mask_count", 64'(mask_count), 64'd0);
            chk("rst_out_valid", 64'(grad_out_valid), 64'd0);
            chk("rst_out_data", 64'(grad_out_data), 64'd0);
            chk("rst_flags", 64'({overflow_err, underflow_err}), 64'd0);
            chk("rst_readys", 64'({fwd_ready, grad_in_ready}), 64'd0);
            mq.delete();
            exp_q.delete();
            pend  = 1'b0;
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            efr = clk_en && (mq.size() < DEPTH);
            egr = clk_en && (mq.size() > 0) && (!pend || grad_out_ready);
            chk("mask_count", 64'(mask_count), 64'(mq.size()));
            chk("out_valid", 64'(grad_out_valid), 64'(pend));
            chk("fwd_ready", 64'(fwd_ready), 64'(efr));
            chk("grad_in_ready", 64'(grad_in_ready), 64'(egr));
            chk("overflow_err", 64'(overflow_err), 64'(ovf_m));
            chk("underflow_err", 64'(underflow_err), 64'(unf_m));
            do_push = fwd_valid && efr;
            do_pop  = grad_in_valid && egr;
            if (clk_en && fwd_valid && mq.size() == DEPTH) ovf_m = 1'b1;
            if (clk_en && grad_in_valid && mq.size() == 0) unf_m = 1'b1;
            #1;
            if (do_pop) begin
                m = mq.pop_front();
                exp_q.push_back(ref_out(m, grad_in_data));
            end
            if (do_push) mq.push_back(ref_mask(fwd_data));
            if (clk_en) begin
                if (do_pop) pend = 1'b1;
                else if (grad_out_ready) pend = 1'b0;
            end
        end
    end

    // Monitor: every accepted output must match the oldest expected vector.
    int n_out = 0;
    always @(negedge clk) begin
        logic [VW-1:0] e;
        if (rst_n && clk_en && grad_out_valid && grad_out_ready) begin
            if (exp_q.size() == 0) begin
                chk("grad_out_unexpected", 64'(grad_out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grad_out_data", 64'(grad_out_data), 64'(e));
                $display("out %0d: data=%h expected=%h", n_out, grad_out_data, e);
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'hFFFF;
            4:       return 16'h0001;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] held;
        rst_n = 1'b0; clk_en = 1'b1;
        fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in_data = '0; grad_out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single push then pop: ch1 positive passes, ch0 negative is zeroed.
        fwd_valid = 1'b1; fwd_data = 32'h0005_FFFB;
        step();
        fwd_valid = 1'b0;
        chk("t1_count", 64'(mask_count), 64'd1);
        grad_in_valid = 1'b1; grad_in_data = 32'h1234_0777;
        step();
        grad_in_valid = 1'b0;
        chk("t1_valid", 64'(grad_out_valid), 64'd1);
        chk("t1_data", 64'(grad_out_data), 64'h1234_0000);
        chk("t1_count_after", 64'(mask_count), 64'd0);
        grad_out_ready = 1'b1;
        step();

        // Fill to full, then an extra forward vector raises overflow.
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data = {pick_val(), pick_val()};
            step();
        end
        chk("t2_full_ready", 64'(fwd_ready), 64'd0);
        step();
        fwd_valid = 1'b0;
        chk("t2_overflow", 64'(overflow_err), 64'd1);
        chk("t2_count", 64'(mask_count), 64'd4);

        // Drain, then gradient on empty FIFO with a same-cycle push.
        grad_in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            grad_in_data = $urandom;
            step();
        end
        chk("t3_empty_ready", 64'(grad_in_ready), 64'd0);
        fwd_valid = 1'b1; fwd_data = 32'h0001_0002;
        step();
        fwd_valid = 1'b0;
        chk("t3_underflow", 64'(underflow_err), 64'd1);
        chk("t3_ready_next", 64'(grad_in_ready), 64'd1);
        step();
        grad_in_valid = 1'b0;
        step();

        // Zero and most-negative forward values both block the gradient.
        fwd_valid = 1'b1; fwd_data = 32'h0000_8000;
        step();
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 32'h7FFF_7FFF;
        step();
        grad_in_valid = 1'b0;
        chk("t4_valid", 64'(grad_out_valid), 64'd1);
        chk("t4_data", 64'(grad_out_data), 64'd0);
        step();

        // Backpressure holds output and blocks pops; release drains in order.
        grad_out_ready = 1'b0;
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data = {pick_val(), pick_val()};
            step();
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = $urandom;
        step();
        held = grad_out_data;
        repeat (3) step();
        chk("t5_stall_ready", 64'(grad_in_ready), 64'd0);
        chk("t5_stall_data", 64'(grad_out_data), 64'(held));
        chk("t5_stall_count", 64'(mask_count), 64'd3);
        grad_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            grad_in_data = $urandom;
            step();
        end
        grad_in_valid = 1'b0;
        step();
        chk("t5_drained", 64'(mask_count), 64'd0);

        // clk_en freeze, then async reset with stored masks and pending output.
        grad_out_ready = 1'b0;
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data = {pick_val(), pick_val()};
            step();
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = $urandom;
        step();
        held = grad_out_data;
        clk_en = 1'b0; fwd_valid = 1'b1; grad_out_ready = 1'b1; grad_in_data = $urandom;
        repeat (5) step();
        chk("t6_freeze_count", 64'(mask_count), 64'd3);
        chk("t6_freeze_valid", 64'(grad_out_valid), 64'd1);
        chk("t6_freeze_data", 64'(grad_out_data), 64'(held));
        clk_en = 1'b1; fwd_valid = 1'b0; grad_in_valid = 1'b0; grad_out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 64'(mask_count), 64'd0);
        chk("t6_rst_valid", 64'(grad_out_valid), 64'd0);
        chk("t6_rst_flags", 64'({overflow_err, underflow_err}), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic with occasional clock-enable gaps.
        for (int i = 0; i < 400; i++) begin
            clk_en         = ($urandom_range(0, 7) != 0);
            fwd_valid      = $urandom_range(0, 1);
            fwd_data       = {pick_val(), pick_val()};
            grad_in_valid  = $urandom_range(0, 1);
            grad_in_data   = {pick_val(), pick_val()};
            grad_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        clk_en = 1'b1; fwd_valid = 1'b0; grad_in_valid = 1'b1; grad_out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        grad_in_valid = 1'b0;
        repeat (2) step();
        chk("final_pending", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
